// File: rtl/controlador_interrupciones_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, register map
// and the fixed-priority encoder.
package controlador_interrupciones_pkg;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    PETICION = 2'd1,
    SERVICIO = 2'd2
  } estado_e;

  localparam logic [15:0] OFS_CTRL   = 16'd0;
  localparam logic [15:0] OFS_PEND   = 16'd1;
  localparam logic [15:0] OFS_ESTADO = 16'd2;

  localparam int BIT_EN = 7;

  // Line 0 wins; only meaningful when at least one bit is set.
  function automatic logic [1:0] prioridad(input logic [2:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else           return 2'd2;
  endfunction

endpackage

// File: rtl/controlador_interrupciones_if.sv
// Bundle of the interrupt pins, the control-unit handshake and the CPU I/O bus.
interface controlador_interrupciones_if #(
  parameter int N_INT    = 3,
  parameter int ANCHO_PC = 10
);
  logic [N_INT-1:0]    interrupciones;
  logic                irq;
  logic                ack;
  logic                fin;
  logic [ANCHO_PC-1:0] vector;
  logic [1:0]          id_int;
  logic [15:0]         dir;
  logic                rd;
  logic                wr;
  logic [7:0]          dato_escrito;
  logic [7:0]          dato_leido;
  logic                sel_lectura;

  modport slave (
    input  interrupciones, ack, fin, dir, rd, wr, dato_escrito,
    output irq, vector, id_int, dato_leido, sel_lectura
  );

  modport master (
    output interrupciones, ack, fin, dir, rd, wr, dato_escrito,
    input  irq, vector, id_int, dato_leido, sel_lectura
  );
endinterface

// File: rtl/controlador_interrupciones_sincronizador_flanco.sv
// Per-line three-flop synchroniser with rising-edge detection on the last two
// stages, so a level held high yields a single one-cycle event.
module sincronizador_flanco (
  input  logic clk,
  input  logic reset,
  input  logic linea_i,
  output logic evento_o
);
  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= linea_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign evento_o = s2_q & ~s3_q;
endmodule

// File: rtl/controlador_interrupciones.sv
// Interrupt controller: pending latch, mask/enable registers on the I/O bus,
// fixed-priority arbitration and the irq/ack/fin handshake with the control unit.
module controlador_interrupciones
  import controlador_interrupciones_pkg::*;
#(
  parameter int                  N_INT    = 3,
  parameter int                  ANCHO_PC = 10,
  parameter logic [ANCHO_PC-1:0] VEC0     = 10'h3F0,
  parameter logic [ANCHO_PC-1:0] VEC1     = 10'h3F4,
  parameter logic [ANCHO_PC-1:0] VEC2     = 10'h3F8,
  parameter logic [15:0]         DIR_BASE = 16'hFF00
) (
  input logic                          clk,
  input logic                          reset,
  controlador_interrupciones_if.slave  bus
);

  logic [N_INT-1:0]    lineas, evento;
  logic [N_INT-1:0]    pend_q, pend_d, mask_q, eleg, clr_ack, clr_w1c;
  logic                en_q;
  estado_e             estado_q;
  logic                irq_q;
  logic [1:0]          id_q, id_nuevo;
  logic [ANCHO_PC-1:0] vector_q;
  logic [7:0]          dato_q, rdata;
  logic                sel_q;
  logic                hit_ctrl, hit_pend, hit_est, hit;

  function automatic logic [ANCHO_PC-1:0] vec_de(input logic [1:0] i);
    case (i)
      2'd0:    return VEC0;
      2'd1:    return VEC1;
      default: return VEC2;
    endcase
  endfunction

  assign lineas = bus.interrupciones;

  sincronizador_flanco u_sinc [N_INT-1:0] (
    .clk      (clk),
    .reset    (reset),
    .linea_i  (lineas),
    .evento_o (evento)
  );

  assign hit_ctrl = (bus.dir == DIR_BASE + OFS_CTRL);
  assign hit_pend = (bus.dir == DIR_BASE + OFS_PEND);
  assign hit_est  = (bus.dir == DIR_BASE + OFS_ESTADO);
  assign hit      = hit_ctrl | hit_pend | hit_est;

  always_comb begin
    clr_ack = '0;
    if (estado_q == PETICION && bus.ack) clr_ack[id_q] = 1'b1;
    clr_w1c = '0;
    if (bus.wr && hit_pend) clr_w1c = bus.dato_escrito[N_INT-1:0];
    // A fresh event in the same cycle as a clear keeps the bit set.
    pend_d   = (pend_q & ~(clr_ack | clr_w1c)) | evento;
    eleg     = pend_q & mask_q & {N_INT{en_q}};
    id_nuevo = prioridad(eleg);
    rdata    = 8'h00;
    if (hit_ctrl)      rdata = {en_q, {(7-N_INT){1'b0}}, mask_q};
    else if (hit_pend) rdata = {{(8-N_INT){1'b0}}, pend_q};
    else if (hit_est)  rdata = {2'b00, estado_q == SERVICIO, irq_q, 2'b00, id_q};
  end

  // Register file; a read in the same cycle as a write returns the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      mask_q <= '0;
      en_q   <= 1'b0;
      dato_q <= 8'h00;
      sel_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (bus.wr && hit_ctrl) begin
        mask_q <= bus.dato_escrito[N_INT-1:0];
        en_q   <= bus.dato_escrito[BIT_EN];
      end
      sel_q  <= bus.rd && hit;
      dato_q <= (bus.rd && hit) ? rdata : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= REPOSO;
      irq_q    <= 1'b0;
      id_q     <= 2'd0;
      vector_q <= VEC0;
    end else begin
      unique case (estado_q)
        REPOSO: if (|eleg) begin
          estado_q <= PETICION;
          irq_q    <= 1'b1;
          id_q     <= id_nuevo;
          vector_q <= vec_de(id_nuevo);
        end
        // id/vector stay frozen here; ack wins over a same-cycle withdrawal.
        PETICION: if (bus.ack) begin
          estado_q <= SERVICIO;
          irq_q    <= 1'b0;
        end else if (!eleg[id_q]) begin
          estado_q <= REPOSO;
          irq_q    <= 1'b0;
        end
        SERVICIO: if (bus.fin) estado_q <= REPOSO;
        default: begin
          estado_q <= REPOSO;
          irq_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.irq         = irq_q;
  assign bus.id_int      = id_q;
  assign bus.vector      = vector_q;
  assign bus.dato_leido  = dato_q;
  assign bus.sel_lectura = sel_q;

endmodule

// File: tb/tb_controlador_interrupciones.sv
// Scoreboard bench: a cycle model built from the controller's rules predicts
// reads and requests; a monitor compares them against what the DUT presents.
module tb_controlador_interrupciones;
  localparam logic [15:0] BASE = 16'hFF00;

  logic clk = 1'b0;
  logic reset;
  controlador_interrupciones_if #(.N_INT(3), .ANCHO_PC(10)) bus ();

  controlador_interrupciones dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit done   = 1'b0;

  bit [7:0] rdq[$];
  bit [1:0] reqq[$];

  // Model state: pending/mask/enable, phase 0=idle 1=requesting 2=serving.
  bit [2:0] m_pend, m_mask;
  bit       m_en;
  int       m_st;
  bit [1:0] m_id;
  bit [2:0] samp[$];  // samp[0] = lines at previous edge, samp[1] two edges back...
  bit       irq_prev;

  function automatic logic [9:0] vec_of(input logic [1:0] id);
    return 10'h3F0 + 10'(id) * 10'd4;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit [2:0] ev, clr, elig;
    bit [15:0] off;
    bit hit;
    if (reset) begin
      m_pend = 0; m_mask = 0; m_en = 0; m_st = 0; m_id = 0;
      samp = '{3'b0, 3'b0, 3'b0};
      return;
    end
    // A line counts as a new event when seen high two edges ago and low three edges ago.
    ev   = samp[1] & ~samp[2];
    off  = bus.dir - BASE;
    hit  = off < 16'd3;
    if (bus.rd && hit) begin
      case (off)
        16'd0:   rdq.push_back({m_en, 4'b0, m_mask});
        16'd1:   rdq.push_back({5'b0, m_pend});
        default: rdq.push_back({2'b0, m_st == 2, m_st == 1, 2'b0, m_id});
      endcase
    end
    elig = m_pend & m_mask & {3{m_en}};
    clr  = 0;
    case (m_st)
      0: if (elig != 0) begin
        for (int i = 2; i >= 0; i--) if (elig[i]) m_id = 2'(i);
        m_st = 1;
        reqq.push_back(m_id);
      end
      1: if (bus.ack) begin
        clr[m_id] = 1'b1;
        m_st = 2;
      end else if (!elig[m_id]) m_st = 0;
      default: if (bus.fin) m_st = 0;
    endcase
    if (bus.wr && hit && off == 16'd1) clr |= bus.dato_escrito[2:0];
    if (bus.wr && hit && off == 16'd0) begin
      m_mask = bus.dato_escrito[2:0];
      m_en   = bus.dato_escrito[7];
    end
    m_pend = (m_pend & ~clr) | ev;
    samp.push_front(bus.interrupciones);
    void'(samp.pop_back());
  endtask

  task automatic mon_step();
    bit [1:0] e;
    chk("irq", bus.irq, m_st == 1);
    chk("id_int", bus.id_int, m_id);
    chk("vector", bus.vector, vec_of(m_id));
    if (bus.irq && !irq_prev) begin
      if (reqq.size() == 0) chk("req_unexpected", bus.irq, 1'b0);
      else begin
        e = reqq.pop_front();
        chk("req_id", bus.id_int, e);
        chk("req_vector", bus.vector, vec_of(e));
      end
    end
    irq_prev = bus.irq;
    if (bus.sel_lectura) begin
      if (rdq.size() == 0) chk("rd_unexpected", bus.sel_lectura, 1'b0);
      else chk("rd_data", bus.dato_leido, rdq.pop_front());
    end else begin
      chk("rd_idle_data", bus.dato_leido, 8'h00);
      if (rdq.size() != 0) begin
        chk("rd_missing", bus.sel_lectura, 1'b1);
        void'(rdq.pop_front());
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_reg(input logic [15:0] ofs, input logic [7:0] d);
    bus.dir = BASE + ofs; bus.dato_escrito = d; bus.wr = 1'b1;
    tick(1);
    bus.wr = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] ofs, input logic [7:0] exp);
    bus.dir = BASE + ofs; bus.rd = 1'b1;
    tick(1);
    bus.rd = 1'b0;
    chk(nm, bus.dato_leido, exp);
  endtask

  task automatic pulse_ack();
    bus.ack = 1'b1; tick(1); bus.ack = 1'b0;
  endtask

  task automatic pulse_fin();
    bus.fin = 1'b1; tick(1); bus.fin = 1'b0;
  endtask

  task automatic wait_irq(input string nm);
    int n = 0;
    while (!bus.irq && n < 40) begin tick(1); n++; end
    chk(nm, bus.irq, 1'b1);
  endtask

  task automatic stimulus();
    reset = 1'b1; tick(3); reset = 1'b0; tick(1);
    rd_chk("rst_ctrl", 0, 8'h00);

    // 1: single line, exact latency, ack clears pending
    wr_reg(0, 8'h87);
    bus.interrupciones = 3'b010; tick(3);
    chk("t1_irq_early", bus.irq, 1'b0);
    tick(1);
    chk("t1_irq", bus.irq, 1'b1);
    chk("t1_id", bus.id_int, 2'd1);
    chk("t1_vec", bus.vector, 10'h3F4);
    tick(1); pulse_ack();
    chk("t1_irq_ack", bus.irq, 1'b0);
    rd_chk("t1_pend", 1, 8'h00);
    rd_chk("t1_estado", 2, 8'h21);
    pulse_fin(); bus.interrupciones = 3'b000; tick(4);

    // 2: simultaneous lines 0 and 2
    bus.interrupciones = 3'b101;
    wait_irq("t2_irq");
    chk("t2_id", bus.id_int, 2'd0);
    chk("t2_vec", bus.vector, 10'h3F0);
    pulse_ack(); pulse_fin();
    wait_irq("t2_irq2");
    chk("t2_id2", bus.id_int, 2'd2);
    chk("t2_vec2", bus.vector, 10'h3F8);
    pulse_ack(); pulse_fin(); bus.interrupciones = 3'b000; tick(4);

    // 3: masked line accumulates, unmask raises irq one edge later
    wr_reg(0, 8'h83);
    bus.interrupciones = 3'b100; tick(2); bus.interrupciones = 3'b000; tick(4);
    rd_chk("t3_pend", 1, 8'h04);
    chk("t3_irq_masked", bus.irq, 1'b0);
    wr_reg(0, 8'h87);
    chk("t3_irq_write_edge", bus.irq, 1'b0);
    tick(1);
    chk("t3_irq", bus.irq, 1'b1);
    chk("t3_id", bus.id_int, 2'd2);
    pulse_ack(); pulse_fin(); tick(2);

    // 4: withdrawal by masking
    bus.interrupciones = 3'b010; tick(2); bus.interrupciones = 3'b000;
    wait_irq("t4_irq");
    wr_reg(0, 8'h85); tick(1);
    chk("t4_irq_withdrawn", bus.irq, 1'b0);
    rd_chk("t4_estado", 2, 8'h01);
    rd_chk("t4_pend", 1, 8'h02);
    wr_reg(1, 8'h02); wr_reg(0, 8'h87); tick(2);
    chk("t4_irq_idle", bus.irq, 1'b0);

    // 5: ack coincides with a new event on the same line
    bus.interrupciones = 3'b010; tick(2); bus.interrupciones = 3'b000;
    wait_irq("t5_irq");
    bus.interrupciones = 3'b010; tick(2);
    bus.ack = 1'b1; tick(1); bus.ack = 1'b0;
    chk("t5_irq_ack", bus.irq, 1'b0);
    rd_chk("t5_pend", 1, 8'h02);
    rd_chk("t5_estado", 2, 8'h21);
    pulse_fin();
    wait_irq("t5_irq_again");
    chk("t5_id", bus.id_int, 2'd1);
    pulse_ack(); pulse_fin(); bus.interrupciones = 3'b000; tick(4);

    // 6: reset during service
    bus.interrupciones = 3'b010; tick(2); bus.interrupciones = 3'b000;
    wait_irq("t6_irq");
    pulse_ack();
    bus.interrupciones = 3'b101; tick(2); bus.interrupciones = 3'b000; tick(3);
    rd_chk("t6_pend", 1, 8'h05);
    reset = 1'b1; tick(1); reset = 1'b0;
    chk("t6_irq_rst", bus.irq, 1'b0);
    pulse_ack(); pulse_fin(); tick(1);
    rd_chk("t6_ctrl", 0, 8'h00);
    rd_chk("t6_pend0", 1, 8'h00);
    rd_chk("t6_estado", 2, 8'h00);
    chk("t6_vec", bus.vector, 10'h3F0);

    // Randomised traffic against the model
    wr_reg(0, 8'h87);
    repeat (2000) begin
      int r;
      if ($urandom_range(0, 7) == 0) bus.interrupciones = bus.interrupciones ^ 3'($urandom_range(1, 7));
      bus.ack = ($urandom_range(0, 4) == 0);
      bus.fin = ($urandom_range(0, 4) == 0);
      r = $urandom_range(0, 9);
      bus.rd = (r < 3) || (r == 9);
      bus.wr = (r == 3) || (r == 4) || (r == 9);
      bus.dir = ($urandom_range(0, 15) == 0) ? 16'($urandom) : BASE + 16'($urandom_range(0, 3));
      bus.dato_escrito = 8'($urandom);
      if ($urandom_range(0, 2) != 0) bus.dato_escrito[7] = 1'b1;
      reset = ($urandom_range(0, 399) == 0);
      tick(1);
    end
    bus.ack = 0; bus.fin = 0; bus.rd = 0; bus.wr = 0; reset = 0; bus.interrupciones = 0;
    tick(5);
  endtask

  initial begin
    reset = 1'b1;
    bus.interrupciones = 3'b000;
    bus.ack = 1'b0; bus.fin = 1'b0;
    bus.dir = 16'h0000; bus.rd = 1'b0; bus.wr = 1'b0; bus.dato_escrito = 8'h00;
    m_pend = 0; m_mask = 0; m_en = 0; m_st = 0; m_id = 0; irq_prev = 0;
    samp = '{3'b0, 3'b0, 3'b0};
    fork
      while (!done) begin @(posedge clk); model_step(); end
      while (!done) begin @(negedge clk); mon_step(); end
      begin stimulus(); done = 1'b1; end
    join
    chk("rdq_drained", rdq.size(), 0);
    chk("reqq_drained", reqq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
